// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Moves bytes from a ring buffer into a UART transmitter, one byte
//            at a time. It also drives the receive flow-control line (rts_n)
//            from the buffer fill level, with hysteresis.
// Ports    :
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   enable            - permits new byte transfers
//   fifo_fill_count   - ring buffer occupancy
//   fifo_rd_valid     - read data valid, one cycle after fifo_rd_en
//   fifo_rd_data      - ring buffer read data
//   fifo_rd_en        - one-cycle ring buffer read strobe
//   tx_busy           - UART transmitter busy
//   tx_start          - one-cycle transmit request
//   tx_data           - byte to transmit, stable from tx_start until IDLE
//   rts_n             - active-low flow control toward the remote sender
//   busy              - high whenever the scheduler is not idle
//   underrun          - sticky flag: read data never arrived
//   tx_count          - count of completed bytes (wraps at 16 bits)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 16,
    parameter int HIGH_WM   = 12,
    parameter int LOW_WM    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [$clog2(RAM_DEPTH):0]   fifo_fill_count,
    input  logic                         fifo_rd_valid,
    input  logic [RAM_WIDTH-1:0]         fifo_rd_data,
    output logic                         fifo_rd_en,
    input  logic                         tx_busy,
    output logic                         tx_start,
    output logic [RAM_WIDTH-1:0]         tx_data,
    output logic                         rts_n,
    output logic                         busy,
    output logic                         underrun,
    output logic [15:0]                  tx_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 C_CNT_W     = $clog2(RAM_DEPTH) + 1;
    // Watermarks are compared unsigned at the width of the fill count.
    localparam logic [C_CNT_W-1:0] C_HIGH_WM   = C_CNT_W'(HIGH_WM);
    localparam logic [C_CNT_W-1:0] C_LOW_WM    = C_CNT_W'(LOW_WM);
    // Number of consecutive cycles without read data before we give up.
    localparam int                 C_TIMEOUT   = 4;
    localparam int                 C_TMO_W     = $clog2(C_TIMEOUT);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST  = C_TMO_W'(C_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    generate
        if ((HIGH_WM <= LOW_WM) || (HIGH_WM > RAM_DEPTH)) begin : g_bad_wm
            $error("uart_tx_sched: need LOW_WM < HIGH_WM <= RAM_DEPTH");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_START     = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_DONE = 3'd5
    } state_t;

    state_t             r_state;
    logic [C_TMO_W-1:0] r_wait_cnt;

    // fifo_rd_en and tx_start are asserted on the edge that enters READ or
    // START and dropped on the edge that leaves it. Each strobe therefore
    // lasts exactly as long as its one-cycle state. That gives the
    // k+1 / k+3 latency from the IDLE decision.
    // The occupancy count is used rather than an empty flag, because an
    // empty flag lags the count by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            tx_count   <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable && (fifo_fill_count != '0) && !tx_busy) begin
                        r_state    <= S_READ;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_READ: begin
                    r_state    <= S_WAIT_DATA;
                    r_wait_cnt <= '0;
                end

                S_WAIT_DATA: begin
                    if (fifo_rd_valid) begin
                        tx_data  <= fifo_rd_data;
                        tx_start <= 1'b1;
                        r_state  <= S_START;
                    end else if (r_wait_cnt == C_TMO_LAST) begin
                        // Give up on the read. Nothing is sent and the
                        // byte counter is left as it was.
                        underrun   <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_START: begin
                    r_state <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    // enable is not consulted here. A started byte always
                    // finishes, and IDLE then decides whether to go on.
                    if (!tx_busy) begin
                        tx_count <= tx_count + 16'd1;
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Receive flow control with hysteresis: deassert (1) at or above the
    // high mark, reassert (0) at or below the low mark, hold in between.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rts_n <= 1'b0;
        end else if (fifo_fill_count >= C_HIGH_WM) begin
            rts_n <= 1'b1;
        end else if (fifo_fill_count <= C_LOW_WM) begin
            rts_n <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched.
//            - A ring-buffer model answers fifo_rd_en one cycle later.
//            - A transmitter model holds tx_busy high for 10 cycles,
//              starting one cycle after tx_start.
//            - Expected bytes are queued when stimulus is issued.
//            - A monitor pops and compares them on every tx_start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int RAM_WIDTH = 8;
    localparam int RAM_DEPTH = 16;
    localparam int HIGH_WM   = 12;
    localparam int LOW_WM    = 4;
    localparam int CW        = $clog2(RAM_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [CW-1:0]        fifo_fill_count;
    logic                 fifo_rd_valid;
    logic [RAM_WIDTH-1:0] fifo_rd_data;
    logic                 fifo_rd_en;
    logic                 tx_busy;
    logic                 tx_start;
    logic [RAM_WIDTH-1:0] tx_data;
    logic                 rts_n;
    logic                 busy;
    logic                 underrun;
    logic [15:0]          tx_count;

    // Bench controls
    logic                 kill_valid;
    logic                 tx_ack_en;
    logic                 manual_fill;
    logic [CW-1:0]        man_fill;
    logic [CW-1:0]        fill_model;
    logic [7:0]           pop_b;
    int                   tx_cnt;

    logic [7:0]           fifo_q[$];
    logic [7:0]           exp_q[$];

    int                   n_checks = 0;
    int                   n_err    = 0;
    int                   cyc      = 0;
    int                   last_rd  = -100;
    int                   n_rd     = 0;
    int                   rd_before;
    logic                 prev_rd  = 1'b0;
    logic                 prev_ts  = 1'b0;
    logic [7:0]           exp_b;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .HIGH_WM   (HIGH_WM),
        .LOW_WM    (LOW_WM)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .fifo_fill_count (fifo_fill_count),
        .fifo_rd_valid   (fifo_rd_valid),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_en      (fifo_rd_en),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .tx_data         (tx_data),
        .rts_n           (rts_n),
        .busy            (busy),
        .underrun        (underrun),
        .tx_count        (tx_count)
    );

    // ------------------------------------------------------------------------
    // Ring buffer model: data valid the cycle after fifo_rd_en. With
    // kill_valid set, the byte is consumed but never presented.
    // ------------------------------------------------------------------------
    initial begin
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = '0;
        fill_model    = '0;
    end

    always @(posedge clk) begin
        fifo_rd_valid <= 1'b0;
        if (fifo_rd_en && (fifo_q.size() != 0)) begin
            pop_b = fifo_q.pop_front();
            if (!kill_valid) begin
                fifo_rd_valid <= 1'b1;
                fifo_rd_data  <= pop_b;
            end
        end
        fill_model <= CW'(fifo_q.size());
    end

    assign fifo_fill_count = manual_fill ? man_fill : fill_model;

    // ------------------------------------------------------------------------
    // Transmitter model: busy for 10 cycles starting the cycle after tx_start
    // ------------------------------------------------------------------------
    initial tx_cnt = 0;

    always @(posedge clk) begin
        if (tx_start && tx_ack_en) tx_cnt <= 10;
        else if (tx_cnt != 0)      tx_cnt <= tx_cnt - 1;
    end

    assign tx_busy = (tx_cnt != 0);

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit exp_out);
        fifo_q.push_back(b);
        if (exp_out) exp_q.push_back(b);
    endtask

    task automatic wait_count(input logic [15:0] target, input int maxc, input string name);
        int i = 0;
        while ((tx_count != target) && (i < maxc)) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(tx_count), 32'(target));
    endtask

    task automatic wait_rd_en(input int maxc, input string name);
        int i = 0;
        while (!fifo_rd_en && (i < maxc)) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(fifo_rd_en), 32'd1);
    endtask

    task automatic wait_tx_start(input int maxc, input string name);
        int i = 0;
        while (!tx_start && (i < maxc)) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_tx_busy(input int maxc, input string name);
        int i = 0;
        while (!tx_busy && (i < maxc)) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(tx_busy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_tx_start"},   32'(tx_start),   32'd0);
        chk({tag, "_tx_data"},    32'(tx_data),    32'd0);
        chk({tag, "_rts_n"},      32'(rts_n),      32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_underrun"},   32'(underrun),   32'd0);
        chk({tag, "_tx_count"},   32'(tx_count),   32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: protocol checks on each read strobe; scoreboard pop on each
    // tx_start
    // ------------------------------------------------------------------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) begin
                n_rd++;
                chk("rd_en_single_cycle", 32'(prev_rd), 32'd0);
                chk("rd_en_with_tx_start", 32'(tx_start), 32'd0);
                chk("rd_en_while_tx_busy", 32'(tx_busy), 32'd0);
                last_rd = cyc;
            end
            if (tx_start) begin
                chk("tx_start_single_cycle", 32'(prev_ts), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_tx_start: got tx_start with tx_data=0x%0h, required no tx_start (t=%0t)",
                             tx_data, $time);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(exp_b));
                    chk("rd_en_to_tx_start_latency", 32'(cyc - last_rd), 32'd2);
                end
            end
        end
        prev_rd = fifo_rd_en;
        prev_ts = tx_start;
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        kill_valid  = 1'b0;
        tx_ack_en   = 1'b1;
        manual_fill = 1'b0;
        man_fill    = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single byte
        enable = 1'b1;
        push_byte(8'h55, 1'b1);
        wait_count(16'd1, 60, "single_tx_count");
        chk("single_busy_low", 32'(busy), 32'd0);
        chk("single_rd_pulses", 32'(n_rd), 32'd1);

        // Burst of three
        push_byte(8'hA1, 1'b1);
        push_byte(8'hB2, 1'b1);
        push_byte(8'hC3, 1'b1);
        wait_count(16'd4, 200, "burst_tx_count");
        chk("burst_busy_low", 32'(busy), 32'd0);
        chk("burst_rd_pulses", 32'(n_rd), 32'd4);
        chk("burst_queue_drained", 32'(exp_q.size()), 32'd0);

        // Watermarks: ramp 0..12, then 11 down to 4
        enable      = 1'b0;
        manual_fill = 1'b1;
        for (int v = 0; v <= 12; v++) begin
            man_fill = CW'(v);
            @(negedge clk);
            chk($sformatf("wm_up_%0d", v), 32'(rts_n), (v == 12) ? 32'd1 : 32'd0);
        end
        for (int v = 11; v >= 4; v--) begin
            man_fill = CW'(v);
            @(negedge clk);
            chk($sformatf("wm_down_%0d", v), 32'(rts_n), (v > 4) ? 32'd1 : 32'd0);
        end
        man_fill    = '0;
        manual_fill = 1'b0;

        // Underrun: the byte is consumed but valid never comes
        kill_valid = 1'b1;
        enable     = 1'b1;
        push_byte(8'h77, 1'b0);
        wait_rd_en(20, "underrun_rd_en_seen");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("underrun_not_yet_%0d", i), 32'(underrun), 32'd0);
        end
        @(negedge clk);
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_back_idle", 32'(busy), 32'd0);
        kill_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        chk("underrun_count_same", 32'(tx_count), 32'd4);

        // Enable drop during WAIT_DONE with two bytes queued
        push_byte(8'hD4, 1'b1);
        push_byte(8'hE5, 1'b0);
        wait_tx_busy(40, "drop_tx_busy_seen");
        @(negedge clk);
        enable = 1'b0;
        wait_count(16'd5, 40, "drop_tx_count");
        rd_before = n_rd;
        repeat (20) @(negedge clk);
        chk("drop_count_held", 32'(tx_count), 32'd5);
        chk("drop_no_new_rd", 32'(n_rd), 32'(rd_before));
        exp_q.push_back(8'hE5);
        enable = 1'b1;
        wait_count(16'd6, 60, "drop_resume_tx_count");

        // Reset while stuck in WAIT_ACK (transmitter never acknowledges)
        tx_ack_en = 1'b0;
        push_byte(8'h3C, 1'b1);
        wait_tx_start(40, "rst_tx_start_seen");
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst       = 1'b0;
        tx_ack_en = 1'b1;
        rd_before = n_rd;
        repeat (10) @(negedge clk);
        chk("midrst_no_rd", 32'(n_rd), 32'(rd_before));
        push_byte(8'h9E, 1'b1);
        wait_count(16'd1, 60, "midrst_fresh_tx_count");

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
